led_pwm_fader: RTL and testbench

LED_PWM_FADER -- requirements
Module: led_pwm_fader

---
 rtl/led_pwm_pkg.sv | 14 +
 rtl/led_pwm_prescaler.sv | 30 +++
 rtl/led_pwm_fader.sv | 104 ++++++++++
 tb/tb_led_pwm_fader.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/led_pwm_pkg.sv
// Shared types and defaults for the LED PWM fader.
package led_pwm_pkg;

   localparam int NUM_CH_DEF     = 11;
   localparam int DECAY_STEP_DEF = 8;

   typedef logic [7:0] duty_t;

   // Saturating subtract used by the optional fade engine.
   function automatic duty_t sat_sub(input duty_t a, input duty_t b);
      return (a > b) ? duty_t'(a - b) : '0;
   endfunction

endpackage

// File: rtl/led_pwm_prescaler.sv
// Free-running divider; tick is high in the cycle the count sits at PRESCALE-1.
module led_pwm_prescaler #(
   parameter int PRESCALE = 32
) (
   input  logic clk,
   input  logic rst_n,
   output logic tick
);

   localparam int            CW   = $clog2(PRESCALE);
   localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_comb begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick = (cnt_q == LAST);

endmodule

// File: rtl/led_pwm_fader.sv
// Multi-channel LED PWM with double-buffered duty updates at the period boundary.
// Define LED_PWM_FADE_EN to let idle channels decay by DECAY_STEP each period.
module led_pwm_fader
   import led_pwm_pkg::*;
#(
   parameter int NUM_CH     = NUM_CH_DEF,
   parameter int PRESCALE   = 32,
   parameter int DECAY_STEP = DECAY_STEP_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              set_valid,
   output logic              set_ready,
   input  logic [3:0]        set_idx,
   input  logic [7:0]        set_duty,
   output logic              idx_err,
   output logic [NUM_CH-1:0] ledc
);

   localparam logic [4:0] NUM_CH_U = 5'(NUM_CH);

   logic       tick;
   logic       boundary;
   logic       accept;
   logic       in_range;
   logic [7:0] pwm_cnt_q;
   logic [7:0] pwm_cnt_d;
   logic       rdy_q;
   logic       idx_err_q;
   logic       idx_err_d;

   led_pwm_prescaler #(
      .PRESCALE(PRESCALE)
   ) u_prescaler (
      .clk  (clk),
      .rst_n(rst_n),
      .tick (tick)
   );

   // Writes are refused only while the staging buffers are being committed.
   assign boundary  = tick && (pwm_cnt_q == 8'hFF);
   assign set_ready = rdy_q && !boundary;
   assign accept    = set_valid && set_ready;
   assign in_range  = ({1'b0, set_idx} < NUM_CH_U);

   always_comb begin
      pwm_cnt_d = tick ? pwm_cnt_q + 8'd1 : pwm_cnt_q;
      idx_err_d = accept && !in_range;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pwm_cnt_q <= '0;
         rdy_q     <= 1'b0;
         idx_err_q <= 1'b0;
      end else begin
         pwm_cnt_q <= pwm_cnt_d;
         rdy_q     <= 1'b1;
         idx_err_q <= idx_err_d;
      end
   end

   assign idx_err = idx_err_q;

   generate
      for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
         duty_t staging_q;
         duty_t active_q;
         duty_t idle_d;
         logic  dirty_q;
         logic  ledc_q;
         logic  wr_hit;

         assign wr_hit = accept && in_range && (set_idx == 4'(gi));

`ifdef LED_PWM_FADE_EN
         assign idle_d = sat_sub(active_q, duty_t'(DECAY_STEP));
`else
         assign idle_d = active_q;
`endif

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               staging_q <= '0;
               active_q  <= '0;
               dirty_q   <= 1'b0;
               ledc_q    <= 1'b0;
            end else begin
               ledc_q <= (pwm_cnt_q < active_q);
               if (boundary) begin
                  active_q <= dirty_q ? staging_q : idle_d;
                  dirty_q  <= 1'b0;
               end else if (wr_hit) begin
                  staging_q <= set_duty;
                  dirty_q   <= 1'b1;
               end
            end
         end

         assign ledc[gi] = ledc_q;
      end
   endgenerate

endmodule

// File: tb/tb_led_pwm_fader.sv
// Self-checking bench for led_pwm_fader against a cycle-count based reference model.
`timescale 1ns/1ps
module tb_led_pwm_fader;

   localparam int NUM_CH = 11;
   localparam int P      = 2;
   localparam int DECAY  = 8;
   localparam int PER    = 256 * P;
   localparam int NPER   = 16;

   logic              clk       = 1'b0;
   logic              rst_n     = 1'b1;
   logic              set_valid = 1'b0;
   logic [3:0]        set_idx   = '0;
   logic [7:0]        set_duty  = '0;
   logic              set_ready;
   logic              idx_err;
   logic [NUM_CH-1:0] ledc;

   led_pwm_fader #(
      .NUM_CH    (NUM_CH),
      .PRESCALE  (P),
      .DECAY_STEP(DECAY)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .set_valid(set_valid),
      .set_ready(set_ready),
      .set_idx  (set_idx),
      .set_duty (set_duty),
      .idx_err  (idx_err),
      .ledc     (ledc)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference state: n_m counts clock edges since reset release.
   int                n_m;
   bit                rdy_m;
   int                stag_m  [NUM_CH];
   int                act_m   [NUM_CH];
   bit                dirty_m [NUM_CH];
   logic [NUM_CH-1:0] ledc_m;
   logic              err_m;
   int                hist    [NUM_CH][NPER];
   int                fade_exp[5];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      assert (obs === exp_v) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp_v, $time);
      end
   endtask

   function automatic int fade(input int a);
`ifdef LED_PWM_FADE_EN
      return (a > DECAY) ? a - DECAY : 0;
`else
      return a;
`endif
   endfunction

   function automatic logic ready_m();
      return rdy_m && ((n_m % PER) != PER - 1);
   endfunction

   task automatic model_clear();
      n_m    = 0;
      rdy_m  = 1'b0;
      ledc_m = '0;
      err_m  = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
         stag_m[i]  = 0;
         act_m[i]   = 0;
         dirty_m[i] = 1'b0;
         for (int p = 0; p < NPER; p++) hist[i][p] = 0;
      end
   endtask

   // Effect of the coming clock edge, given the currently driven inputs.
   task automatic model_edge();
      bit bnd;
      int cnt;
      bnd = ((n_m % PER) == PER - 1);
      cnt = (n_m / P) % 256;
      for (int i = 0; i < NUM_CH; i++) ledc_m[i] = (cnt < act_m[i]);
      err_m = 1'b0;
      if (bnd) begin
         for (int i = 0; i < NUM_CH; i++) begin
            act_m[i]   = dirty_m[i] ? stag_m[i] : fade(act_m[i]);
            dirty_m[i] = 1'b0;
         end
      end else if (rdy_m && set_valid) begin
         if (int'(set_idx) < NUM_CH) begin
            stag_m[set_idx]  = int'(set_duty);
            dirty_m[set_idx] = 1'b1;
         end else begin
            err_m = 1'b1;
         end
      end
      n_m++;
      rdy_m = 1'b1;
   endtask

   task automatic cyc();
      int p;
      model_edge();
      @(posedge clk);
      #1;
      chk("ledc", 32'(ledc), 32'(ledc_m));
      chk("set_ready", 32'(set_ready), 32'(ready_m()));
      chk("idx_err", 32'(idx_err), 32'(err_m));
      p = (n_m - 1) / PER;
      if (p < NPER) begin
         for (int i = 0; i < NUM_CH; i++) hist[i][p] += int'(ledc[i]);
      end
   endtask

   task automatic run_to(input int target);
      while (n_m < target) cyc();
   endtask

   task automatic do_reset();
      set_valid = 1'b0;
      set_idx   = '0;
      set_duty  = '0;
      #2 rst_n = 1'b0;
      #1;
      chk("rst_ledc", 32'(ledc), 32'd0);
      chk("rst_ready", 32'(set_ready), 32'd0);
      chk("rst_idx_err", 32'(idx_err), 32'd0);
      model_clear();
      @(negedge clk);
      #1 rst_n = 1'b1;
   endtask

   initial begin
`ifdef LED_PWM_FADE_EN
      fade_exp = '{20, 12, 4, 0, 0};
`else
      fade_exp = '{20, 20, 20, 20, 20};
`endif

      // Power-on reset, then ready from the first edge after release.
      #3;
      do_reset();
      cyc();
      chk("ready_after_release", 32'(set_ready), 32'd1);
      cyc();

      // Random writes, including out-of-range indices, over several periods.
      repeat (3 * PER + 137) begin
         set_valid = ($urandom_range(0, 3) == 0);
         set_idx   = 4'($urandom_range(0, 15));
         set_duty  = 8'($urandom_range(0, 255));
         cyc();
      end

      // Mid-period reset drops everything, including pending staged writes.
      do_reset();
      cyc();
      chk("ready_after_midreset", 32'(set_ready), 32'd1);

      // Directed writes: duty 64, 255, 0 and an out-of-range index.
      set_valid = 1'b1; set_idx = 4'd3; set_duty = 8'd64;
      cyc();
      set_idx = 4'd4; set_duty = 8'd255;
      cyc();
      set_idx = 4'd0; set_duty = 8'd0;
      cyc();
      set_idx = 4'd12; set_duty = 8'd99;
      cyc();
      chk("idx_err_pulse", 32'(idx_err), 32'd1);
      set_valid = 1'b0;
      cyc();
      chk("idx_err_clear", 32'(idx_err), 32'd0);
      run_to(2 * PER);
      chk("ch3_before_boundary", 32'(hist[3][0]), 32'd0);
      chk("ch3_duty64", 32'(hist[3][1]), 32'(64 * P));
      chk("ch4_duty255", 32'(hist[4][1]), 32'(255 * P));
      chk("ch0_duty0", 32'(hist[0][1]), 32'd0);
      chk("ch2_untouched", 32'(hist[2][1]), 32'd0);

      // Write held across the boundary cycle is accepted on the following edge.
      run_to(3 * PER - 1);
      set_valid = 1'b1; set_idx = 4'd7; set_duty = 8'd100;
      #1;
      chk("ready_low_at_boundary", 32'(set_ready), 32'd0);
      cyc();
      chk("ready_high_after_boundary", 32'(set_ready), 32'd1);
      cyc();
      set_valid = 1'b0;
      run_to(5 * PER);
      chk("ch7_pending_period", 32'(hist[7][3]), 32'd0);
      chk("ch7_applied_period", 32'(hist[7][4]), 32'(100 * P));

      // Fade behaviour of an idle channel across successive periods.
      do_reset();
      set_valid = 1'b1; set_idx = 4'd5; set_duty = 8'd20;
      cyc();
      cyc();
      set_valid = 1'b0;
      run_to(6 * PER);
      for (int k = 0; k < 5; k++) begin
         chk($sformatf("ch5_fade_period%0d", k + 1), 32'(hist[5][k + 1]), 32'(fade_exp[k] * P));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
